// File: rtl/ahb_bram_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : ahb_bram_ctrl
// Description : Zero-wait-state AHB-Lite slave that maps bus transfers onto a
//               dual-port BRAM (byte-enabled write port A, registered read
//               port B). Forwards write data into an immediately following
//               read of the same word.
// Revision    : 1.0 - initial release
// ============================================================================
module ahb_bram_ctrl #(
    parameter int ADDR_WIDTH = 14
) (
    input  logic                  HCLK,
    input  logic                  HRESETn,
    input  logic                  HSEL,
    input  logic [31:0]           HADDR,
    input  logic [1:0]            HTRANS,
    input  logic [2:0]            HSIZE,
    input  logic                  HWRITE,
    input  logic [31:0]           HWDATA,
    input  logic                  HREADY,
    output logic                  HREADYOUT,
    output logic                  HRESP,
    output logic [31:0]           HRDATA,
    output logic [ADDR_WIDTH-1:0] bram_addra,
    output logic [31:0]           bram_dina,
    output logic [3:0]            bram_wea,
    output logic [ADDR_WIDTH-1:0] bram_addrb,
    input  logic [31:0]           bram_doutb
);

    logic                  w_acc;
    logic [3:0]            w_mask;
    logic [ADDR_WIDTH-1:0] w_word;
    logic [31:0]           w_merged;
    logic                  w_fwd_hit;

    logic                  r_wr_pend;
    logic [3:0]            r_wr_mask;
    logic [ADDR_WIDTH-1:0] r_wr_addr;
    logic                  r_rd_pend;
    logic [3:0]            r_fwd_mask;
    logic [31:0]           r_fwd_data;

    assign w_acc  = HSEL & HTRANS[1] & HREADY;
    assign w_word = HADDR[ADDR_WIDTH+1:2];

    always_comb begin
        w_mask = 4'b1111;
        case (HSIZE)
            3'd0:    w_mask = 4'b0001 << HADDR[1:0];
            3'd1:    w_mask = HADDR[1] ? 4'b1100 : 4'b0011;
            default: w_mask = 4'b1111;
        endcase
    end

    // A read address phase overlapping a write data phase to the same word
    // sees pre-write RAM contents, so capture the in-flight write bytes.
    assign w_fwd_hit = r_wr_pend & w_acc & ~HWRITE & (w_word == r_wr_addr);

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            r_wr_pend  <= 1'b0;
            r_wr_mask  <= 4'b0000;
            r_wr_addr  <= '0;
            r_rd_pend  <= 1'b0;
            r_fwd_mask <= 4'b0000;
            r_fwd_data <= 32'h0;
        end else begin
            r_wr_pend <= w_acc & HWRITE;
            r_rd_pend <= w_acc & ~HWRITE;
            if (w_acc && HWRITE) begin
                r_wr_addr <= w_word;
                r_wr_mask <= w_mask;
            end
            if (w_fwd_hit) begin
                r_fwd_mask <= r_wr_mask;
                r_fwd_data <= HWDATA;
            end else begin
                r_fwd_mask <= 4'b0000;
            end
        end
    end

    generate
        for (genvar i = 0; i < 4; i++) begin : g_lane
            assign w_merged[i*8 +: 8] = r_fwd_mask[i] ? r_fwd_data[i*8 +: 8]
                                                      : bram_doutb[i*8 +: 8];
        end
    endgenerate

    assign bram_addra = r_wr_addr;
    assign bram_dina  = HWDATA;
    assign bram_wea   = r_wr_pend ? r_wr_mask : 4'b0000;
    assign bram_addrb = w_word;

    assign HRDATA    = r_rd_pend ? w_merged : 32'h0;
    assign HREADYOUT = 1'b1;
    assign HRESP     = 1'b0;

    logic w_unused;
    assign w_unused = ^{HADDR[31:ADDR_WIDTH+2], HTRANS[0]};

endmodule
`default_nettype wire

// File: tb/tb_ahb_bram_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_ahb_bram_ctrl
// Description : Directed self-checking bench for ahb_bram_ctrl with a
//               behavioural dual-port BRAM attached.
// Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_ahb_bram_ctrl;

    localparam int ADDR_WIDTH = 14;

    logic                  clk;
    logic                  rst_n;
    logic                  hsel;
    logic [31:0]           haddr;
    logic [1:0]            htrans;
    logic [2:0]            hsize;
    logic                  hwrite;
    logic [31:0]           hwdata;
    logic                  hready;
    logic                  hreadyout;
    logic                  hresp;
    logic [31:0]           hrdata;
    logic [ADDR_WIDTH-1:0] bram_addra;
    logic [31:0]           bram_dina;
    logic [3:0]            bram_wea;
    logic [ADDR_WIDTH-1:0] bram_addrb;
    logic [31:0]           bram_doutb;

    int n_checks = 0;
    int n_errors = 0;

    ahb_bram_ctrl #(.ADDR_WIDTH(ADDR_WIDTH)) dut (
        .HCLK       (clk),
        .HRESETn    (rst_n),
        .HSEL       (hsel),
        .HADDR      (haddr),
        .HTRANS     (htrans),
        .HSIZE      (hsize),
        .HWRITE     (hwrite),
        .HWDATA     (hwdata),
        .HREADY     (hready),
        .HREADYOUT  (hreadyout),
        .HRESP      (hresp),
        .HRDATA     (hrdata),
        .bram_addra (bram_addra),
        .bram_dina  (bram_dina),
        .bram_wea   (bram_wea),
        .bram_addrb (bram_addrb),
        .bram_doutb (bram_doutb)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural BRAM: read-before-write, registered read port
    logic [31:0] mem [0:(1<<ADDR_WIDTH)-1];
    always @(posedge clk) begin
        for (int i = 0; i < 4; i++)
            if (bram_wea[i]) mem[bram_addra][i*8 +: 8] <= bram_dina[i*8 +: 8];
        bram_doutb <= mem[bram_addrb];
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // One bus cycle: present an address phase (and the HWDATA of the previous
    // one), then return at the falling edge so outputs can be sampled.
    task automatic drive(input logic sel, input logic [1:0] trans, input logic wr,
                         input logic [2:0] size, input logic [31:0] addr,
                         input logic [31:0] wdata, input logic rdy);
        @(posedge clk);
        #1;
        hsel   = sel;
        htrans = trans;
        hwrite = wr;
        hsize  = size;
        haddr  = addr;
        hwdata = wdata;
        hready = rdy;
        @(negedge clk);
    endtask

    task automatic wr_a(input logic [31:0] addr, input logic [2:0] size, input logic [31:0] wdata);
        drive(1'b1, 2'b10, 1'b1, size, addr, wdata, 1'b1);
    endtask

    task automatic rd_a(input logic [31:0] addr, input logic [31:0] wdata);
        drive(1'b1, 2'b10, 1'b0, 3'd2, addr, wdata, 1'b1);
    endtask

    task automatic idle(input logic [31:0] wdata);
        drive(1'b0, 2'b00, 1'b0, 3'd2, 32'h0, wdata, 1'b1);
    endtask

    initial begin
        rst_n  = 1'b0;
        hsel   = 1'b0;
        htrans = 2'b00;
        hwrite = 1'b0;
        hsize  = 3'd2;
        haddr  = 32'h0;
        hwdata = 32'h0;
        hready = 1'b1;
        #3;
        check("rst_wea", {28'h0, bram_wea}, 32'h0);
        check("rst_hrdata", hrdata, 32'h0);
        check("rst_hreadyout", {31'h0, hreadyout}, 32'h1);
        check("rst_hresp", {31'h0, hresp}, 32'h0);
        #9 rst_n = 1'b1;

        // Reset during read data phase, then during write data phase
        wr_a(32'h0, 3'd2, 32'h0);
        idle(32'h55AA55AA);
        rd_a(32'h0, 32'h0);
        idle(32'h0);
        check("rd_before_rst", hrdata, 32'h55AA55AA);
        #2 rst_n = 1'b0;
        #1 check("rst_rd_hrdata", hrdata, 32'h0);
        #1 rst_n = 1'b1;
        wr_a(32'h0, 3'd2, 32'h0);
        idle(32'hFFFFFFFF);
        check("wr_wea_pre_rst", {28'h0, bram_wea}, 32'hF);
        #2 rst_n = 1'b0;
        #1 check("rst_wr_wea", {28'h0, bram_wea}, 32'h0);
        check("rst_wr_hrdata", hrdata, 32'h0);
        #1 rst_n = 1'b1;
        check("post_rst_hreadyout", {31'h0, hreadyout}, 32'h1);
        check("post_rst_hresp", {31'h0, hresp}, 32'h0);
        rd_a(32'h0, 32'h0);
        idle(32'h0);
        check("lost_write", hrdata, 32'h55AA55AA);

        // Word write then read, non-adjacent
        wr_a(32'h100, 3'd2, 32'h0);
        idle(32'hDEADBEEF);
        check("w2_wea", {28'h0, bram_wea}, 32'hF);
        check("w2_addra", {18'h0, bram_addra}, 32'h40);
        check("w2_dina", bram_dina, 32'hDEADBEEF);
        rd_a(32'h100, 32'h0);
        check("w2_idle_wea", {28'h0, bram_wea}, 32'h0);
        check("w2_idle_hrdata", hrdata, 32'h0);
        check("w2_addrb", {18'h0, bram_addrb}, 32'h40);
        idle(32'h0);
        check("w2_rdata", hrdata, 32'hDEADBEEF);

        // Byte / half lanes
        wr_a(32'h200, 3'd2, 32'h0);
        wr_a(32'h201, 3'd0, 32'h11223344);
        check("l_word_wea", {28'h0, bram_wea}, 32'hF);
        wr_a(32'h202, 3'd1, 32'h0000AA00);
        check("l_byte_wea", {28'h0, bram_wea}, 32'h2);
        idle(32'hBBCC0000);
        check("l_half_wea", {28'h0, bram_wea}, 32'hC);
        rd_a(32'h200, 32'h0);
        idle(32'h0);
        check("l_rdata", hrdata, 32'hBBCCAA44);

        // Forwarding
        wr_a(32'h300, 3'd2, 32'h0);
        wr_a(32'h304, 3'd2, 32'h0);
        wr_a(32'h303, 3'd0, 32'h12345678);
        rd_a(32'h300, 32'h5A000000);
        check("f_wea", {28'h0, bram_wea}, 32'h8);
        check("f_addra", {18'h0, bram_addra}, 32'hC0);
        wr_a(32'h300, 3'd0, 32'h0);
        check("f_hit_rdata", hrdata, 32'h5A000000);
        rd_a(32'h304, 32'h00000099);
        check("f_miss_wea", {28'h0, bram_wea}, 32'h1);
        idle(32'h0);
        check("f_miss_rdata", hrdata, 32'h12345678);
        rd_a(32'h300, 32'h0);
        idle(32'h0);
        check("f_ram_rdata", hrdata, 32'h5A000099);

        // Back-to-back pipeline and non-transfer cycles
        wr_a(32'h400, 3'd2, 32'h0);
        rd_a(32'h304, 32'hCAFEF00D);
        check("p_wa_wea", {28'h0, bram_wea}, 32'hF);
        check("p_wa_addra", {18'h0, bram_addra}, 32'h100);
        wr_a(32'h500, 3'd2, 32'h0);
        check("p_rb_rdata", hrdata, 32'h12345678);
        check("p_rb_wea", {28'h0, bram_wea}, 32'h0);
        rd_a(32'h400, 32'h0BADC0DE);
        check("p_wc_wea", {28'h0, bram_wea}, 32'hF);
        check("p_wc_addra", {18'h0, bram_addra}, 32'h140);
        drive(1'b0, 2'b10, 1'b1, 3'd2, 32'h400, 32'h0, 1'b1);
        check("p_ra_rdata", hrdata, 32'hCAFEF00D);
        drive(1'b1, 2'b01, 1'b1, 3'd2, 32'h400, 32'h0, 1'b1);
        check("p_nosel_wea", {28'h0, bram_wea}, 32'h0);
        check("p_nosel_hrdata", hrdata, 32'h0);
        drive(1'b1, 2'b10, 1'b0, 3'd2, 32'h500, 32'h0, 1'b0);
        check("p_busy_wea", {28'h0, bram_wea}, 32'h0);
        check("p_busy_hrdata", hrdata, 32'h0);
        rd_a(32'h500, 32'h0);
        check("p_stall_hrdata", hrdata, 32'h0);
        idle(32'h0);
        check("p_rc_rdata", hrdata, 32'h0BADC0DE);

        // Address alias and HSIZE=3
        wr_a(32'h0001_0004, 3'd3, 32'h0);
        idle(32'hA5A5A5A5);
        check("a_addra", {18'h0, bram_addra}, 32'h1);
        check("a_wea", {28'h0, bram_wea}, 32'hF);
        rd_a(32'h4, 32'h0);
        idle(32'h0);
        check("a_rdata", hrdata, 32'hA5A5A5A5);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
